psum_unpack_acc: RTL

PSUM_UNPACK_ACC -- requirements
Module: psum_unpack_acc

---
 rtl/opu_pkg.sv | 35 +++
 rtl/lane_sat_add.sv | 24 ++
 rtl/psum_unpack_acc.sv | 118 +++++++++++
 3 files changed

// File: rtl/opu_pkg.sv
// Shared definitions for the product-word unpack/accumulate path.
package opu_pkg;

  localparam int unsigned LANES_INT8X4  = 4;
  localparam int unsigned LANES_INT16X2 = 2;
  localparam int unsigned LANES_MAX     = 4;
  localparam int unsigned P_W           = 32;
  localparam int unsigned RAW_W         = 16;

  localparam logic MODE_INT16X2 = 1'b0;
  localparam logic MODE_INT8X4  = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } opu_state_e;

  // Extract lane idx of a packed product word as a 16-bit signed value
  function automatic logic [RAW_W-1:0] lane_raw(input logic [P_W-1:0] p,
                                                input logic           mode,
                                                input int unsigned    idx);
    logic [P_W-1:0] sh;
    logic [RAW_W-1:0] r;
    r = '0;
    if (mode == MODE_INT8X4) begin
      sh = p >> (8 * idx);
      r  = {{8{sh[7]}}, sh[7:0]};
    end else if (idx < LANES_INT16X2) begin
      sh = p >> (16 * idx);
      r  = sh[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_sat_add.sv
// Signed saturating adder for one accumulator lane.
module lane_sat_add #(
  parameter int unsigned ACC_W = 24
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [ACC_W-1:0] add_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             sat_o
);

  logic [ACC_W:0] wide;

  // One extra bit exposes overflow; clamp to the signed bound of the true sign
  always_comb begin
    wide  = {acc_i[ACC_W-1], acc_i} + {add_i[ACC_W-1], add_i};
    sum_o = wide[ACC_W-1:0];
    sat_o = 1'b0;
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      sat_o = 1'b1;
      sum_o = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/psum_unpack_acc.sv
// Unpacks int8x4 / int16x2 product words and accumulates per-lane dot-product sums.
module psum_unpack_acc
  import opu_pkg::*;
#(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [P_W-1:0]       p,
  input  logic                 p_mode,
  input  logic                 p_valid,
  input  logic                 p_last,
  output logic                 p_ready,
  input  logic                 flush,
  output logic [4*ACC_W-1:0]   acc_data,
  output logic                 acc_mode,
  output logic [CNT_W-1:0]     acc_len,
  output logic [3:0]           acc_sat,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic                 err_mode
);

  opu_state_e                           state_q;
  logic                                 mode_q;
  logic [LANES_MAX-1:0][ACC_W-1:0]      acc_q;
  logic [CNT_W-1:0]                     cnt_q;
  logic [LANES_MAX-1:0]                 sat_q;

  logic                                 beat_fire;
  logic                                 first_beat;
  logic                                 eff_mode;
  logic [LANES_MAX-1:0][ACC_W-1:0]      addend;
  logic [LANES_MAX-1:0][ACC_W-1:0]      acc_base;
  logic [LANES_MAX-1:0][ACC_W-1:0]      sum_d;
  logic [LANES_MAX-1:0]                 lane_sat;
  logic [LANES_MAX-1:0]                 sat_d;
  logic [CNT_W-1:0]                     cnt_base;
  logic [CNT_W-1:0]                     cnt_d;

  // Input handshake: blocked by flush or by an undrained result
  assign p_ready    = !flush && (!acc_valid || acc_ready);
  assign beat_fire  = p_valid && p_ready;
  assign first_beat = (state_q == IDLE);
  // Mode is taken from the first beat and held for the rest of the vector
  assign eff_mode   = first_beat ? p_mode : mode_q;

  for (genvar gi = 0; gi < LANES_MAX; gi++) begin : g_lane
    logic [RAW_W-1:0] raw;
    assign raw          = lane_raw(p, eff_mode, gi);
    assign addend[gi]   = {{(ACC_W-RAW_W){raw[RAW_W-1]}}, raw};
    assign acc_base[gi] = first_beat ? '0 : acc_q[gi];

    lane_sat_add #(.ACC_W(ACC_W)) u_add (
      .acc_i (acc_base[gi]),
      .add_i (addend[gi]),
      .sum_o (sum_d[gi]),
      .sat_o (lane_sat[gi])
    );
  end

  // Per-vector sticky saturation and saturating beat count
  always_comb begin
    sat_d    = (first_beat ? '0 : sat_q) | lane_sat;
    cnt_base = first_beat ? '0 : cnt_q;
    cnt_d    = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
  end

  // FSM, accumulators and result register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mode_q    <= MODE_INT16X2;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= '0;
      acc_data  <= '0;
      acc_mode  <= MODE_INT16X2;
      acc_len   <= '0;
      acc_sat   <= '0;
      acc_valid <= 1'b0;
      err_mode  <= 1'b0;
    end else begin
      if (acc_valid && acc_ready) begin
        acc_valid <= 1'b0;
      end
      if (flush) begin
        state_q <= IDLE;
        acc_q   <= '0;
        cnt_q   <= '0;
        sat_q   <= '0;
      end else if (beat_fire) begin
        if (!first_beat && (p_mode != mode_q)) begin
          err_mode <= 1'b1;
        end
        if (p_last) begin
          acc_data  <= sum_d;
          acc_mode  <= eff_mode;
          acc_len   <= cnt_d;
          acc_sat   <= sat_d;
          acc_valid <= 1'b1;
          state_q   <= IDLE;
          acc_q     <= '0;
          cnt_q     <= '0;
          sat_q     <= '0;
        end else begin
          state_q <= ACCUM;
          mode_q  <= eff_mode;
          acc_q   <= sum_d;
          cnt_q   <= cnt_d;
          sat_q   <= sat_d;
        end
      end
    end
  end

endmodule
